instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, giving the queue entry count (power of two, 2..16).
REQ-002 The block SHALL have the parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 Ports SHALL be as follows (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- redirect_i  in  1  branch/jump taken; flush the queue and restart fetch.
- redirect_pc_i  in  32  new fetch address, valid when redirect_i=1.
- imem_addr_o  out  32  fetch address to the combinational instruction memory.
- imem_req_o  out  1  high when this cycle's fetch is accepted into the queue.
- imem_instr_i  in  32  instruction read at imem_addr_o in the same cycle.
- out_valid_o  out  1  queue head is valid.
- out_instr_o  out  32  head instruction; 0 (nop) when empty.
- out_pc_plus4_o  out  32  head fetch address + 4; 0 when empty.
- out_ready_i  in  1  consumer (IF/ID register write enable) accepts the head.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-004 The block SHALL hold a fetch_pc register; imem_addr_o SHALL equal {fetch_pc[31:2], 2'b00} combinationally.
REQ-005 pop SHALL be defined as out_valid_o & out_ready_i.
REQ-006 push SHALL be defined as !redirect_i & (count_o < DEPTH | pop); imem_req_o SHALL equal push.
REQ-007 On push, the block SHALL write {fetch_pc+4, imem_instr_i} at the tail and increment fetch_pc by 4 at the edge, wrapping modulo 2^32.
REQ-008 On pop, the block SHALL advance the head pointer; out_* SHALL present the next entry in the following cycle.
REQ-009 Simultaneous push and pop SHALL leave count_o unchanged, including when count_o=DEPTH (the popped slot is reused in the same cycle).
REQ-010 Head and tail pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or drop below 0.
REQ-011 The queue SHALL be non-fall-through: an instruction pushed at edge N SHALL be visible on out_* no earlier than the cycle after edge N.
REQ-012 out_valid_o SHALL equal (count_o != 0); out_instr_o and out_pc_plus4_o SHALL be 0 whenever count_o = 0.
REQ-013 When redirect_i=1, at the edge the block SHALL clear all entries (count 0, pointers 0), set fetch_pc to {redirect_pc_i[31:2], 2'b00}, and perform no push.
REQ-014 A pop coinciding with redirect_i SHALL still be reported to the consumer (out_* valid that cycle), but the queue SHALL be empty after the edge.
REQ-015 When out_ready_i=0 and count_o=DEPTH, push SHALL be 0, and fetch_pc and all entries SHALL hold.

Reset
REQ-016 At an edge with rst_i=1, the block SHALL set fetch_pc to RESET_PC, count and pointers to 0, and all entry storage to 0; rst_i SHALL take priority over redirect_i.
REQ-017 After reset, out_valid_o SHALL be 0, out_instr_o 0, out_pc_plus4_o 0, count_o 0, and imem_addr_o RESET_PC.
REQ-018 Reset asserted mid-operation SHALL discard all queued entries within the same edge.

Verification
REQ-019 The bench SHALL cover all of the following scenarios:
- Reset, then out_ready_i=1 and memory word = address: imem_addr_o runs 0,4,8,...; out_valid_o rises one cycle after reset release; out_instr_o=0 and out_pc_plus4_o=4 first; one instruction per cycle.
- Stall fill, with out_ready_i=0 and DEPTH=4: after 4 pushes, count_o=4, imem_req_o=0, imem_addr_o holds at 0x10; the head stays at instr 0.
- Full, then pop: with count_o=4 and out_ready_i=1 for one cycle, push and pop occur together, count_o stays 4, and the next head is pc_plus4=8.
- Redirect with redirect_pc_i=0x0000_0103 while 3 entries are queued: the next cycle shows count_o=0, out_valid_o=0, out_instr_o=0, imem_addr_o=0x100; the instruction at 0x100 appears one cycle later.
- Wrap: redirect to 0xFFFF_FFF8 and run 4 fetches: addresses are FFFF_FFF8, FFFF_FFFC, 0, 4; pc_plus4 values are FFFF_FFFC, 0, 4, 8.
- Reset and redirect asserted together: the state is RESET_PC with an empty queue.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: fetches sequentially from a combinational
// instruction memory and buffers {pc+4, instr} pairs for the decode stage.
// A redirect flushes the queue and restarts fetch at the new address.
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   output logic [31:0]              imem_addr_o,
   output logic                     imem_req_o,
   input  logic [31:0]              imem_instr_i,
   output logic                     out_valid_o,
   output logic [31:0]              out_instr_o,
   output logic [31:0]              out_pc_plus4_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [CNT_W-1:0] count_r;
   logic [31:0]      instr_mem [DEPTH];
   logic [31:0]      pc4_mem   [DEPTH];

   logic pop;
   logic push;

   // Redirect targets are word aligned; the low bits are deliberately dropped.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   // Pointers wrap naturally because DEPTH is a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return p + PTR_W'(1);
   endfunction

   assign imem_addr_o    = {fetch_pc[31:2], 2'b00};
   assign out_valid_o    = (count_r != '0);
   assign out_instr_o    = out_valid_o ? instr_mem[head_ptr] : 32'h0;
   assign out_pc_plus4_o = out_valid_o ? pc4_mem[head_ptr]   : 32'h0;
   assign count_o        = count_r;

   // A slot freed by this cycle's pop may be refilled in the same cycle.
   assign pop        = out_valid_o & out_ready_i;
   assign push       = !redirect_i & ((count_r < FULL_CNT) | pop);
   assign imem_req_o = push;

   // Control state: fetch address, pointers and occupancy; reset beats redirect.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc <= RESET_PC;
         head_ptr <= '0;
         tail_ptr <= '0;
         count_r  <= '0;
      end else if (redirect_i) begin
         fetch_pc <= {redirect_pc_i[31:2], 2'b00};
         head_ptr <= '0;
         tail_ptr <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            tail_ptr <= ptr_inc(tail_ptr);
         end
         if (pop) begin
            head_ptr <= ptr_inc(head_ptr);
         end
         if (push && !pop) begin
            count_r <= count_r + CNT_W'(1);
         end else if (pop && !push) begin
            count_r <= count_r - CNT_W'(1);
         end
      end
   end

   // Entry storage: cleared on reset, written at the tail on every accepted fetch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= 32'h0;
            pc4_mem[i]   <= 32'h0;
         end
      end else if (push) begin
         instr_mem[tail_ptr] <= imem_instr_i;
         pc4_mem[tail_ptr]   <= fetch_pc + 32'd4;
      end
   end

endmodule
